// File: rtl/basic_print_fmt_pkg.sv
// ---------------------------------------------------------------------------
// basic_print_pkg
// Shared types and constants for the BASIC print formatter.
//   - item_kind_t : print item kinds carried through the FIFO
//   - state_t     : formatter FSM states
//   - POW10       : decimal place values used by the digit converter
//   - ASCII_*     : bytes the formatter emits on its own
// Optional feature macro: BASIC_PRINT_HEX_EN (adds the hex nibble helper).
// ---------------------------------------------------------------------------
package basic_print_pkg;

    typedef enum logic [1:0] {
        KIND_INT     = 2'd0,
        KIND_CHAR    = 2'd1,
        KIND_NEWLINE = 2'd2,
        KIND_HEX     = 2'd3
    } item_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // FIFO entry: {kind[1:0], data[31:0]}
    localparam int ITEM_W = 34;

    localparam logic [31:0] POW10 [0:9] = '{
        32'd1,        32'd10,        32'd100,        32'd1000,
        32'd10000,    32'd100000,    32'd1000000,    32'd10000000,
        32'd100000000, 32'd1000000000
    };

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_X     = 8'h78;
    localparam logic [7:0] ASCII_A     = 8'h41;

`ifdef BASIC_PRINT_HEX_EN
    // Byte for hex output position k: k = 8 is the 'x' of the prefix,
    // k = 7..0 selects the nibble v[4k+3:4k] as an uppercase hex digit.
    function automatic logic [7:0] hex_char(input logic [31:0] v, input logic [3:0] k);
        logic [31:0] sh;
        logic [3:0]  nib;
        sh  = v >> {k[2:0], 2'b00};
        nib = sh[3:0];
        if (k == 4'd8) begin
            hex_char = ASCII_X;
        end else if (nib < 4'd10) begin
            hex_char = ASCII_0 + {4'd0, nib};
        end else begin
            hex_char = ASCII_A + {4'd0, nib} - 8'd10;
        end
    endfunction
`endif

endpackage

// File: rtl/basic_print_fmt_fifo.sv
// ---------------------------------------------------------------------------
// basic_print_fifo
// Registered-storage FIFO holding print items between producer and formatter.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_push, i_wdata   : write request and entry; ignored while full
//   i_pop             : read request; ignored while empty
//   o_rdata           : head entry (valid while not empty)
//   o_full, o_empty   : occupancy flags derived from the pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module basic_print_fifo
    import basic_print_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [ITEM_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [ITEM_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [ITEM_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_rdata = r_mem[r_rd_ptr[PW-2:0]];

    // Qualify requests with the flags so overflow/underflow cannot occur.
    always_comb begin
        w_do_push = 1'b0;
        w_do_pop  = 1'b0;
        if (i_push && !o_full) begin
            w_do_push = 1'b1;
        end else begin
            w_do_push = 1'b0;
        end
        if (i_pop && !o_empty) begin
            w_do_pop = 1'b1;
        end else begin
            w_do_pop = 1'b0;
        end
    end

    // Storage and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {ITEM_W{1'b0}};
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[PW-2:0]] <= i_wdata;
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/basic_print_fmt.sv
// ---------------------------------------------------------------------------
// basic_print_fmt
// Turns BASIC print items (INT, CHAR, NEWLINE, optional HEX) into an ASCII
// byte stream on a valid/ready interface.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   i_item_valid/o_item_ready : item handshake (ready = FIFO not full)
//   i_item_kind, i_item_data  : item kind and 32-bit payload
//   o_out_valid/i_out_ready   : byte handshake
//   o_out_data                : ASCII byte, stable while valid
//   o_busy                    : FIFO non-empty or formatter active
// Optional feature macro: BASIC_PRINT_HEX_EN formats kind 3 as "0x" plus
// 8 uppercase hex digits; without it kind 3 is accepted and dropped.
// ---------------------------------------------------------------------------
module basic_print_fmt
    import basic_print_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_item_valid,
    output logic        o_item_ready,
    input  logic [1:0]  i_item_kind,
    input  logic [31:0] i_item_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [7:0]  o_out_data,
    output logic        o_busy
);

    logic [ITEM_W-1:0] w_fifo_rdata;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    item_kind_t        w_kind;
    logic [31:0]       w_data;

    state_t      r_state;
    logic [31:0] r_mag;      // remaining magnitude (or hex payload)
    logic [3:0]  r_pidx;     // decimal place / remaining-byte index
    logic [3:0]  r_digit;
    logic        r_started;  // a digit has been emitted: stop suppressing zeros
    logic        r_out_valid;
    logic [7:0]  r_out_data;
`ifdef BASIC_PRINT_HEX_EN
    logic        r_hex;
`endif

    basic_print_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (i_item_valid),
        .i_wdata ({i_item_kind, i_item_data}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_kind       = item_kind_t'(w_fifo_rdata[33:32]);
    assign w_data       = w_fifo_rdata[31:0];
    assign o_item_ready = !w_fifo_full;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_busy       = !w_fifo_empty || (r_state != ST_IDLE);

    // Pop the FIFO head whenever the formatter is idle and work is waiting.
    always_comb begin
        w_pop = 1'b0;
        if ((r_state == ST_IDLE) && !w_fifo_empty) begin
            w_pop = 1'b1;
        end else begin
            w_pop = 1'b0;
        end
    end

    // Formatter FSM. r_pidx doubles as "bytes still to come": a '-' sign is
    // loaded with 10 so the EMIT exit step lands on place 9, and single-byte
    // items use 0 so EMIT returns straight to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mag       <= 32'd0;
            r_pidx      <= 4'd0;
            r_digit     <= 4'd0;
            r_started   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
`ifdef BASIC_PRINT_HEX_EN
            r_hex       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_digit   <= 4'd0;
                        r_started <= 1'b0;
                        case (w_kind)
                            KIND_CHAR: begin
                                r_out_data  <= w_data[7:0];
                                r_out_valid <= 1'b1;
                                r_pidx      <= 4'd0;
                                r_state     <= ST_EMIT;
                            end
                            KIND_NEWLINE: begin
                                r_out_data  <= ASCII_LF;
                                r_out_valid <= 1'b1;
                                r_pidx      <= 4'd0;
                                r_state     <= ST_EMIT;
                            end
                            KIND_INT: begin
                                if (w_data[31]) begin
                                    // Negate as unsigned so -2^31 maps to 2^31.
                                    r_mag       <= ~w_data + 32'd1;
                                    r_out_data  <= ASCII_MINUS;
                                    r_out_valid <= 1'b1;
                                    r_pidx      <= 4'd10;
                                    r_state     <= ST_EMIT;
                                end else begin
                                    r_mag   <= w_data;
                                    r_pidx  <= 4'd9;
                                    r_state <= ST_CONV;
                                end
                            end
`ifdef BASIC_PRINT_HEX_EN
                            KIND_HEX: begin
                                r_mag       <= w_data;
                                r_out_data  <= ASCII_0;
                                r_out_valid <= 1'b1;
                                r_pidx      <= 4'd9;
                                r_hex       <= 1'b1;
                                r_state     <= ST_EMIT;
                            end
`endif
                            default: begin
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    if (r_mag >= POW10[r_pidx]) begin
                        r_mag   <= r_mag - POW10[r_pidx];
                        r_digit <= r_digit + 4'd1;
                    end else if ((r_digit != 4'd0) || r_started || (r_pidx == 4'd0)) begin
                        r_out_data  <= ASCII_0 + {4'd0, r_digit};
                        r_out_valid <= 1'b1;
                        r_started   <= 1'b1;
                        r_state     <= ST_EMIT;
                    end else begin
                        // Leading zero: move to the next place without emitting.
                        r_pidx  <= r_pidx - 4'd1;
                        r_digit <= 4'd0;
                    end
                end
                ST_EMIT: begin
                    if (i_out_ready) begin
                        if (r_pidx == 4'd0) begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_IDLE;
`ifdef BASIC_PRINT_HEX_EN
                            r_hex       <= 1'b0;
`endif
                        end
`ifdef BASIC_PRINT_HEX_EN
                        else if (r_hex) begin
                            // Hex bytes go back to back with no conversion cycles.
                            r_out_data <= hex_char(r_mag, r_pidx - 4'd1);
                            r_pidx     <= r_pidx - 4'd1;
                        end
`endif
                        else begin
                            r_out_valid <= 1'b0;
                            r_pidx      <= r_pidx - 4'd1;
                            r_digit     <= 4'd0;
                            r_state     <= ST_CONV;
                        end
                    end else begin
                        r_state <= ST_EMIT;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_basic_print_fmt.sv
// ---------------------------------------------------------------------------
// tb_basic_print_fmt
// Directed bench for basic_print_fmt. Each accepted item pushes its expected
// ASCII bytes (formatted independently with $sformatf) onto a queue; a
// monitor pops and compares every byte taken on the output handshake.
// ---------------------------------------------------------------------------
module tb_basic_print_fmt;

    logic        clk;
    logic        rst_n;
    logic        i_item_valid;
    logic        o_item_ready;
    logic [1:0]  i_item_kind;
    logic [31:0] i_item_data;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [7:0]  o_out_data;
    logic        o_busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_exp;
    logic        mon_have;

    basic_print_fmt #(
        .DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_item_valid (i_item_valid),
        .o_item_ready (o_item_ready),
        .i_item_kind  (i_item_kind),
        .i_item_data  (i_item_data),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (o_out_data),
        .o_busy       (o_busy)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait slips past its own budget.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, one byte per handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && o_out_valid === 1'b1 && i_out_ready === 1'b1) begin
            n_vec++;
            mon_have = (exp_q.size() > 0);
            mon_exp  = 8'h00;
            if (mon_have) begin
                mon_exp = exp_q.pop_front();
            end
            assert (mon_have && (o_out_data === mon_exp)) else begin
                n_err++;
                $error("FAIL out_byte: observed %02h expected %02h (queue had entry=%0d)",
                       o_out_data, mon_exp, mon_have);
            end
        end
    end

    // Drive one item, wait (bounded) for acceptance, and queue its bytes.
    task automatic push(input logic [1:0] kind, input logic [31:0] data);
        string s;
        int    budget;
        s = "";
        @(negedge clk);
        i_item_valid = 1'b1;
        i_item_kind  = kind;
        i_item_data  = data;
        budget = 200;
        while (o_item_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("push_accept", {31'd0, o_item_ready}, 32'd1);
        case (kind)
            2'd0: s = $sformatf("%0d", $signed(data));
            2'd1: s = "";
            2'd2: s = "";
`ifdef BASIC_PRINT_HEX_EN
            2'd3: s = {"0x", $sformatf("%08X", data)};
`endif
            default: s = "";
        endcase
        if (kind == 2'd1) begin
            exp_q.push_back(data[7:0]);
        end else if (kind == 2'd2) begin
            exp_q.push_back(8'h0A);
        end else begin
            for (int i = 0; i < s.len(); i++) begin
                exp_q.push_back(s[i]);
            end
        end
        @(posedge clk);
        #1;
        i_item_valid = 1'b0;
    endtask

    // Wait (bounded) for every expected byte to appear and the block to go idle.
    task automatic drain(input string tag);
        int budget;
        budget = 2000;
        while ((exp_q.size() != 0 || o_busy !== 1'b0) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check({tag, "_pending"}, exp_q.size(), 32'd0);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int budget;
        budget = 200;
        while (o_out_valid !== 1'b1 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check(tag, {31'd0, o_out_valid}, 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        i_item_valid = 1'b0;
        i_item_kind  = 2'd0;
        i_item_data  = 32'd0;
        i_out_ready  = 1'b0;

        // Reset values
        #12;
        check("rst_item_ready", {31'd0, o_item_ready}, 32'd1);
        check("rst_out_valid",  {31'd0, o_out_valid},  32'd0);
        check("rst_out_data",   {24'd0, o_out_data},   32'd0);
        check("rst_busy",       {31'd0, o_busy},       32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // CHAR latency: valid rises one edge after the accept edge
        i_out_ready = 1'b1;
        push(2'd1, 32'h41);
        check("char_valid_at_accept", {31'd0, o_out_valid}, 32'd0);
        check("char_busy_at_accept",  {31'd0, o_busy},      32'd1);
        @(posedge clk);
        #1;
        check("char_valid_next", {31'd0, o_out_valid}, 32'd1);
        check("char_data_next",  {24'd0, o_out_data},  32'h41);
        drain("char");

        // Integers, including zero and a negative
        push(2'd0, 32'd0);
        push(2'd0, 32'd1234);
        push(2'd0, 32'hFFFF_FFF9);
        drain("ints");

        // Most negative value followed by a newline
        push(2'd0, 32'h8000_0000);
        push(2'd2, 32'd0);
        drain("minint");

        // Zero in the middle places and a large value
        push(2'd0, 32'd1000);
        push(2'd0, 32'd1999999999);
        drain("zeros");

        // Stall: 9 items with the consumer blocked, FIFO fills
        i_out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            push(2'd1, 32'h61 + k);
        end
        push(2'd0, 32'd42);
        check("stall_item_ready", {31'd0, o_item_ready}, 32'd0);
        check("stall_out_valid",  {31'd0, o_out_valid},  32'd1);
        check("stall_busy",       {31'd0, o_busy},       32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("stall_data_hold",  {24'd0, o_out_data},   32'h61);
        check("stall_still_full", {31'd0, o_item_ready}, 32'd0);
        i_out_ready = 1'b1;
        drain("stall");

        // Reset in the middle of "1234"
        i_out_ready = 1'b0;
        push(2'd0, 32'd1234);
        wait_valid("mid_first_digit");
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        i_out_ready = 1'b0;
        wait_valid("mid_second_digit");
        check("mid_remaining", exp_q.size(), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",      {31'd0, o_out_valid},  32'd0);
        check("mid_rst_busy",       {31'd0, o_busy},       32'd0);
        check("mid_rst_item_ready", {31'd0, o_item_ready}, 32'd1);
        check("mid_rst_data",       {24'd0, o_out_data},   32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        i_out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_valid", {31'd0, o_out_valid}, 32'd0);
        check("post_rst_busy",  {31'd0, o_busy},      32'd0);
        push(2'd1, 32'h21);
        drain("post_rst");

        // Kind 3: hex with the feature, silently dropped without it
        push(2'd3, 32'd255);
        drain("hex255");
        push(2'd3, 32'hDEAD_BEEF);
        push(2'd1, 32'h2E);
        drain("hex_mix");
        check("end_out_valid", {31'd0, o_out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
